divider_unit: RTL and testbench
===============================

DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 The block SHALL have no parameters; the data width SHALL be fixed at 32 bits (RV32M).
REQ-002 i_clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_start  input  1  request; sampled only in IDLE.
REQ-005 i_kill  input  1  abort the current operation (pipeline flush).
REQ-006 i_op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
REQ-007 i_op1  input  32  dividend.
REQ-008 i_op2  input  32  divisor.
REQ-009 o_ready  output  1  high exactly when the state is IDLE.
REQ-010 o_done  output  1  one-cycle pulse; o_result is valid in that cycle.
REQ-011 o_result  output  32  quotient or remainder.

Function
REQ-012 States SHALL be IDLE, CALC, FIX and DONE.
- IDLE->CALC on i_start.
- CALC->FIX after 32 iterations.
- FIX->DONE.
- DONE->IDLE unconditionally.
REQ-013 On accept, the block SHALL latch the operand magnitudes (absolute values for DIV/REM, raw values for DIVU/REMU), the result signs and i_op, and SHALL load the iteration counter with 31.
REQ-014 CALC SHALL perform one radix-2 restoring step per cycle using a 33-bit trial subtract (remainder shifted left by one, minus divisor); the carry/sign of that subtract selects restore or keep, and the quotient bit is shifted in.
REQ-015 FIX SHALL negate the quotient if the operand signs differ (DIV), and SHALL negate the remainder if the dividend is negative (REM).
REQ-016 Latency: with i_start sampled in cycle N, o_done SHALL be high in cycle N+34 only, and o_ready SHALL rise in cycle N+35.
REQ-017 o_result SHALL be registered and SHALL hold its value until the next o_done.
REQ-018 i_start outside IDLE SHALL be ignored; no queuing.
REQ-019 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF, and REM/REMU SHALL return the unmodified dividend.
REQ-020 Signed overflow (0x80000000 / 0xFFFFFFFF): DIV SHALL return 0x80000000, and REM SHALL return 0.
REQ-021 i_kill in any state SHALL force IDLE on the next edge, with no o_done pulse and o_result unchanged.
REQ-022 If i_kill and i_start are both high in IDLE, i_kill SHALL win and the request SHALL be dropped.
REQ-023 Operands SHALL be sampled only at accept; changes to i_op1/i_op2/i_op during CALC SHALL have no effect.

Reset
REQ-024 Asserting i_reset SHALL immediately force the following, including mid-operation:
- state IDLE, counter 0;
- o_ready=1, o_done=0, o_result=0;
- internal quotient and remainder registers 0.
REQ-025 After release, the first i_start SHALL be accepted on the first rising edge.

Configuration
REQ-026 Macro DIVIDER_EARLY_EXIT_EN:
- When defined, a divide by zero or signed overflow detected at accept SHALL go IDLE->DONE directly, giving o_done in cycle N+1 with the REQ-019/REQ-020 results.
- When undefined, these cases SHALL take the full N+34 latency with identical results.
- Normal operands SHALL take N+34 in both builds.

Verification
REQ-027 DIVU 100/7: o_done at N+34 with o_result=14; REMU 100/7 gives 2.
REQ-028 DIV -7/2 gives 0xFFFFFFFD (-3); REM -7/2 gives 0xFFFFFFFF (-1); DIV 7/-2 gives 0xFFFFFFFD.
REQ-029 DIV 0x80000000/0xFFFFFFFF gives 0x80000000, and REM gives 0. Latency SHALL be N+1 with DIVIDER_EARLY_EXIT_EN and N+34 without.
REQ-030 Divide by zero: DIVU 0x1234/0 gives 0xFFFFFFFF; REMU 0x1234/0 gives 0x1234; DIV -20/0 gives 0xFFFFFFFF; REM -20/0 gives 0xFFFFFFEC.
REQ-031 Abort cases: i_kill at N+10 gives o_ready=1 at N+11 and no o_done; a new DIVU 9/3 accepted at N+11 gives 3 at N+45.
REQ-032 Reset and ignored start:
- i_reset pulsed at N+20 SHALL give o_ready=1 immediately and o_result=0.
- i_start held high throughout CALC SHALL cause no extra operation until the state returns to IDLE.

Source files
------------

// File: rtl/divider_unit.sv
// divider_unit -- 32-bit RV32M iterative divider (DIV, DIVU, REM, REMU).
//
// Radix-2 restoring divider: one quotient bit per cycle, 32 iterations,
// then a sign-fix cycle. With i_start sampled in cycle N, o_done pulses in
// cycle N+34 and o_ready returns in cycle N+35.
//
// Ports:
//   i_clk     in   1   clock, rising edge
//   i_reset   in   1   asynchronous active-high reset
//   i_start   in   1   request, sampled only while idle
//   i_kill    in   1   abort (pipeline flush); beats i_start
//   i_op      in   2   00=DIV 01=DIVU 10=REM 11=REMU
//   i_op1     in  32   dividend
//   i_op2     in  32   divisor
//   o_ready   out  1   high while idle
//   o_done    out  1   one-cycle pulse, o_result valid
//   o_result  out 32   quotient or remainder, held until the next o_done
//
// Build option:
//   DIVIDER_EARLY_EXIT_EN  divide-by-zero and signed overflow skip the
//                          iterations and finish in cycle N+1.

module divider_unit (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_kill,
   input  logic [1:0]  i_op,
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   output logic        o_ready,
   output logic        o_done,
   output logic [31:0] o_result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state, state_nxt;
   logic [4:0]  count;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] dvsr;
   logic        op_is_rem;
   logic        q_neg;
   logic        r_neg;

   logic        op_signed;
   logic        op1_neg;
   logic        op2_neg;
   logic [31:0] op1_mag;
   logic [31:0] op2_mag;
   logic        accept;
   logic [32:0] trial;
   logic        trial_neg;

   assign op_signed = ~i_op[0];
   assign op1_neg   = op_signed & i_op1[31];
   assign op2_neg   = op_signed & i_op2[31];
   assign op1_mag   = op1_neg ? (~i_op1 + 32'd1) : i_op1;
   assign op2_mag   = op2_neg ? (~i_op2 + 32'd1) : i_op2;
   assign accept    = (state == IDLE) & i_start & ~i_kill;

   // Partial remainder is always below the divisor, so the shifted value
   // minus the divisor fits a 33-bit signed range; bit 32 is the borrow.
   assign trial     = {rem, quo[31]} - {1'b0, dvsr};
   assign trial_neg = trial[32];

`ifdef DIVIDER_EARLY_EXIT_EN
   logic        early_exit;
   logic        div_zero;
   logic [31:0] early_result;

   assign div_zero   = (i_op2 == '0);
   assign early_exit = div_zero |
                       (op_signed & (i_op1 == 32'h8000_0000) & (i_op2 == '1));

   always_comb begin
      early_result = '0;
      if (div_zero)
         early_result = i_op[1] ? i_op1 : '1;
      else
         early_result = i_op[1] ? '0 : 32'h8000_0000;
   end
`endif

   // State register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      if (i_kill) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
`ifdef DIVIDER_EARLY_EXIT_EN
                  state_nxt = early_exit ? DONE : CALC;
`else
                  state_nxt = CALC;
`endif
               end
            end
            CALC:    if (count == 5'd0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign o_ready = (state == IDLE);
   assign o_done  = (state == DONE);

   // Datapath. A kill freezes everything, which keeps o_result intact.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         count     <= '0;
         quo       <= '0;
         rem       <= '0;
         dvsr      <= '0;
         op_is_rem <= 1'b0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         o_result  <= '0;
      end else if (!i_kill) begin
         case (state)
            IDLE: begin
               if (accept) begin
                  quo       <= op1_mag;
                  rem       <= '0;
                  dvsr      <= op2_mag;
                  count     <= 5'd31;
                  op_is_rem <= i_op[1];
                  // Divide by zero keeps the all-ones quotient unsigned.
                  q_neg     <= (op1_neg ^ op2_neg) & (i_op2 != '0);
                  r_neg     <= op1_neg;
`ifdef DIVIDER_EARLY_EXIT_EN
                  if (early_exit)
                     o_result <= early_result;
`endif
               end
            end
            CALC: begin
               rem <= trial_neg ? {rem[30:0], quo[31]} : trial[31:0];
               quo <= {quo[30:0], ~trial_neg};
               if (count != 5'd0)
                  count <= count - 5'd1;
            end
            FIX: begin
               if (op_is_rem)
                  o_result <= r_neg ? (~rem + 32'd1) : rem;
               else
                  o_result <= q_neg ? (~quo + 32'd1) : quo;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_unit.sv
// tb_divider_unit -- directed bench for divider_unit with a behavioural
// reference (plain integer division plus the RV32M corner-case rules) and a
// per-cycle compare process covering o_ready, o_done and o_result.

module tb_divider_unit;

   logic        i_clk;
   logic        i_reset;
   logic        i_start;
   logic        i_kill;
   logic [1:0]  i_op;
   logic [31:0] i_op1;
   logic [31:0] i_op2;
   logic        o_ready;
   logic        o_done;
   logic [31:0] o_result;

   divider_unit dut (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_start  (i_start),
      .i_kill   (i_kill),
      .i_op     (i_op),
      .i_op1    (i_op1),
      .i_op2    (i_op2),
      .o_ready  (o_ready),
      .o_done   (o_done),
      .o_result (o_result)
   );

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Model state: written by the driver except exp_hold (compare process).
   bit          exp_active  = 1'b0;
   int          exp_acc     = 0;
   int          exp_done_at = 0;
   logic [31:0] exp_pend    = '0;
   logic [31:0] exp_lit     = '0;
   logic [31:0] exp_hold    = '0;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] ref_result(input logic [1:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'd0)
         return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         OP_DIV:  return 32'(sa / sb);
         OP_DIVU: return a / b;
         OP_REM:  return 32'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [1:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
`ifdef DIVIDER_EARLY_EXIT_EN
      if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
         return 1;
`else
      if (op == 2'b00 && a == 32'h0 && b == 32'h1)
         return 34;
`endif
      return 34;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Compare process: every cycle, away from the active edge.
   initial begin
      bit busy;
      bit is_done;
      forever begin
         @(negedge i_clk);
         if (i_reset)
            exp_hold = '0;
         busy    = exp_active && (cyc > exp_acc) && (cyc <= exp_done_at);
         is_done = exp_active && (cyc == exp_done_at);
         chk("ready", {31'd0, o_ready}, {31'd0, !busy});
         chk("done",  {31'd0, o_done},  {31'd0, is_done});
         if (is_done) begin
            chk("result_model",   o_result, exp_pend);
            chk("result_literal", o_result, exp_lit);
            exp_hold = exp_pend;
         end else begin
            chk("result_hold", o_result, exp_hold);
         end
      end
   end

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit,
                         input bit hold, input bit scramble, output int lat);
      i_op        = op;
      i_op1       = a;
      i_op2       = b;
      i_start     = 1'b1;
      lat         = ref_latency(op, a, b);
      exp_pend    = ref_result(op, a, b);
      exp_lit     = lit;
      exp_acc     = cyc;
      exp_done_at = cyc + lat;
      exp_active  = 1'b1;
      tick();
      if (!hold)
         i_start = 1'b0;
      if (scramble) begin
         i_op1 = 32'hDEAD_BEEF;
         i_op2 = 32'h0000_0001;
         i_op  = OP_REMU;
      end
   endtask

   task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit,
                        input bit hold, input bit scramble);
      int lat;
      launch(op, a, b, lit, hold, scramble, lat);
      repeat (lat) tick();
      i_start = 1'b0;
   endtask

   initial begin
      int lat;
      i_reset = 1'b1;
      i_start = 1'b0;
      i_kill  = 1'b0;
      i_op    = OP_DIVU;
      i_op1   = '0;
      i_op2   = '0;
      repeat (2) tick();
      i_reset = 1'b0;

      // Accepted on the first edge after release.
      do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
      do_op(OP_REMU, 32'd100, 32'd7, 32'd2,  1'b0, 1'b0);
      do_op(OP_DIV,  -32'sd7, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
      do_op(OP_REM,  -32'sd7, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0);
      do_op(OP_DIV,  32'd7, -32'sd2, 32'hFFFF_FFFD, 1'b0, 1'b0);
      do_op(OP_REM,  32'd7, -32'sd2, 32'd1, 1'b0, 1'b0);
      do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
      do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      do_op(OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      do_op(OP_REMU, 32'h1234, 32'd0, 32'h1234, 1'b0, 1'b0);
      do_op(OP_DIV,  -32'sd20, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      do_op(OP_REM,  -32'sd20, 32'd0, 32'hFFFF_FFEC, 1'b0, 1'b0);
      do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      do_op(OP_DIVU, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      do_op(OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0);
      do_op(OP_DIV,  -32'sd1000, -32'sd7, 32'd142, 1'b0, 1'b0);

      // Operands changed during CALC have no effect.
      do_op(OP_DIVU, 32'd1000, 32'd9, 32'd111, 1'b0, 1'b1);
      // i_start held high through the whole operation: no extra request.
      do_op(OP_REMU, 32'd1000, 32'd9, 32'd1, 1'b1, 1'b0);
      repeat (3) tick();

      // Kill at N+10, new request at N+11.
      launch(OP_DIVU, 32'd1000, 32'd3, 32'd333, 1'b0, 1'b0, lat);
      repeat (9) tick();
      i_kill = 1'b1;
      tick();
      i_kill = 1'b0;
      exp_active = 1'b0;
      do_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 1'b0, 1'b0);

      // Kill during the sign-fix cycle: no pulse, result untouched.
      launch(OP_DIV, 32'd1000, -32'sd3, 32'hFFFF_FEB3, 1'b0, 1'b0, lat);
      repeat (32) tick();
      i_kill = 1'b1;
      tick();
      i_kill = 1'b0;
      exp_active = 1'b0;
      repeat (3) tick();

      // Kill and start together while idle: request dropped.
      i_op    = OP_DIVU;
      i_op1   = 32'd50;
      i_op2   = 32'd5;
      i_start = 1'b1;
      i_kill  = 1'b1;
      tick();
      i_start = 1'b0;
      i_kill  = 1'b0;
      repeat (40) tick();

      // Asynchronous reset mid-operation at N+20.
      launch(OP_DIVU, 32'hFFFF, 32'h10, 32'hFFF, 1'b0, 1'b0, lat);
      repeat (19) tick();
      #1;
      i_reset = 1'b1;
      exp_active = 1'b0;
      tick();
      i_reset = 1'b0;
      do_op(OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
